// File: rtl/ifft_pkg.sv
// Shared types for the 8-point IFFT twiddle address sequencer.
// Holds FSM state encoding, transform size and twiddle group geometry.
package ifft_pkg;

  localparam int N          = 8;
  localparam int LOG2N      = 3;
  localparam int GRP_ENTRIES = 4;
  localparam int GRP_SHIFT  = 2;
  localparam int ADDR_W     = 5;
  localparam int LAST_STAGE = LOG2N - 1;
  localparam int BF_PER_STG = N / 2;

  typedef logic [LOG2N-1:0]  idx_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [1:0]        stg_t;
  typedef logic [1:0]        bfly_t;
  typedef logic [2:0]        grp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bf_index_calc.sv
// Combinational butterfly index and twiddle address for one (stage, bfly).
// Ports: i_s stage, i_b butterfly, i_grp group -> o_addr, o_idx_a, o_idx_b.
module bf_index_calc
  import ifft_pkg::*;
(
  input  logic [1:0] i_s,
  input  logic [1:0] i_b,
  input  logic [2:0] i_grp,
  output logic [4:0] o_addr,
  output logic [2:0] o_idx_a,
  output logic [2:0] o_idx_b
);

  logic [1:0] w_k;
  logic [2:0] w_a;
  logic [2:0] w_span;

  // k = (b mod 2^s) << (2-s); idx_a = (b>>s)*2^(s+1) + (b mod 2^s)
  always_comb begin
    w_k    = '0;
    w_a    = '0;
    w_span = 3'd1;
    unique case (1'b1)
      (i_s == 2'd0): begin
        w_k    = 2'd0;
        w_a    = {i_b, 1'b0};
        w_span = 3'd1;
      end
      (i_s == 2'd1): begin
        w_k    = {i_b[0], 1'b0};
        w_a    = {i_b[1], 1'b0, i_b[0]};
        w_span = 3'd2;
      end
      (i_s == 2'd2): begin
        w_k    = i_b;
        w_a    = {1'b0, i_b};
        w_span = 3'd4;
      end
      default: begin
        w_k    = '0;
        w_a    = '0;
        w_span = 3'd1;
      end
    endcase
  end

  // k < 4, so grp*4 + k is a plain concatenation
  assign o_addr  = {i_grp, w_k};
  assign o_idx_a = w_a;
  assign o_idx_b = w_a + w_span;

endmodule

// File: rtl/twiddle_addr_seq.sv
// Twiddle ROM address / butterfly index sequencer for one 8-point frame.
// In: clk, rst, start, grp_sel, bf_ready. Out: rom_addr, rom_en, tw_valid,
// idx_a, idx_b, stage, busy, done, err.
module twiddle_addr_seq
  import ifft_pkg::*;
#(
  parameter int STAGE_GAP  = 2,
  parameter int NUM_GROUPS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] grp_sel,
  input  logic       bf_ready,
  output logic [4:0] rom_addr,
  output logic       rom_en,
  output logic       tw_valid,
  output logic [2:0] idx_a,
  output logic [2:0] idx_b,
  output logic [1:0] stage,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LP_NGRP = 4'(NUM_GROUPS);
  localparam logic [3:0] LP_GAP  = 4'(STAGE_GAP);
  localparam logic [1:0] LP_LAST = 2'(LAST_STAGE);
  localparam logic [1:0] LP_BMAX = 2'(BF_PER_STG - 1);

  state_t     r_state;
  logic [1:0] r_s;
  logic [1:0] r_b;
  logic [2:0] r_grp;
  logic [3:0] r_gap_cnt;
  logic [4:0] r_addr_last;
  logic       r_tw_valid;
  logic [2:0] r_idx_a;
  logic [2:0] r_idx_b;
  logic [1:0] r_stage;
  logic       r_err;

  logic       w_issue;
  logic [4:0] w_addr;
  logic [2:0] w_idx_a;
  logic [2:0] w_idx_b;
  logic       w_grp_ok;

  bf_index_calc u_calc (
    .i_s     (r_s),
    .i_b     (r_b),
    .i_grp   (r_grp),
    .o_addr  (w_addr),
    .o_idx_a (w_idx_a),
    .o_idx_b (w_idx_b)
  );

  // Issue depends on this cycle's bf_ready, so it cannot be registered
  assign w_issue  = (r_state == ST_RUN) && bf_ready;
  assign w_grp_ok = ({1'b0, grp_sel} < LP_NGRP);

  assign rom_en   = w_issue;
  assign rom_addr = w_issue ? w_addr : r_addr_last;
  assign tw_valid = r_tw_valid;
  assign idx_a    = r_idx_a;
  assign idx_b    = r_idx_b;
  assign stage    = r_stage;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_b         <= '0;
      r_grp       <= '0;
      r_gap_cnt   <= '0;
      r_addr_last <= '0;
      r_tw_valid  <= 1'b0;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_stage     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_tw_valid <= w_issue;

      // Pipeline copy models the one-cycle synchronous ROM read
      if (w_issue) begin
        r_addr_last <= w_addr;
        r_idx_a     <= w_idx_a;
        r_idx_b     <= w_idx_b;
        r_stage     <= r_s;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_grp_ok) begin
              r_grp   <= grp_sel;
              r_s     <= '0;
              r_b     <= '0;
              r_state <= ST_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (bf_ready) begin
            if (r_b == LP_BMAX) begin
              r_b <= '0;
              if (r_s == LP_LAST) begin
                r_state <= ST_DRAIN;
              end else if (LP_GAP == 4'd0) begin
                r_s <= r_s + 2'd1;
              end else begin
                r_gap_cnt <= LP_GAP - 4'd1;
                r_state   <= ST_GAP;
              end
            end else begin
              r_b <= r_b + 2'd1;
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_s     <= r_s + 2'd1;
            r_state <= ST_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end

        ST_DRAIN: begin
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_addr_seq.sv
// Directed bench for twiddle_addr_seq with a pair-enumeration model.
// Checks issue order, pipeline alignment, timing, err, stall and reset.
module tb_twiddle_addr_seq;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] grp_sel = '0;
  logic       bf_ready = 1'b1;
  logic [4:0] rom_addr;
  logic       rom_en;
  logic       tw_valid;
  logic [2:0] idx_a;
  logic [2:0] idx_b;
  logic [1:0] stage;
  logic       busy;
  logic       done;
  logic       err;

  twiddle_addr_seq #(
    .STAGE_GAP  (GAP),
    .NUM_GROUPS (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .grp_sel  (grp_sel),
    .bf_ready (bf_ready),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .tw_valid (tw_valid),
    .idx_a    (idx_a),
    .idx_b    (idx_b),
    .stage    (stage),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // model, written by stimulus only
  int e_addr[12];
  int e_a[12];
  int e_b[12];
  int e_s[12];
  int gen = 0;
  bit model_ok = 0;
  int t0 = 0;

  // monitor state, written by the compare process only
  int  seen_gen = 0;
  bit  active = 0;
  int  iss_i = 0;
  int  tv_i = 0;
  bit  prev_en = 0;
  int  last_addr = 0;
  int  last_a = 0;
  int  last_b = 0;
  int  last_s = 0;
  int  done_cnt = 0;
  int  addr_log[$];

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic flag(string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Stage s pairs every j with bit s clear to j + 2^s, ascending j.
  task automatic load_model(int g);
    int n;
    n = 0;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 8; j++) begin
        if (((j >> s) & 1) == 0) begin
          e_a[n]    = j;
          e_b[n]    = j + (1 << s);
          e_s[n]    = s;
          e_addr[n] = g * 4 + (j % (1 << s)) * (4 >> s);
          n++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen;
      active   = model_ok;
      iss_i    = 0;
      tv_i     = 0;
      addr_log.delete();
    end
    if (rst) begin
      active    = 0;
      prev_en   = 0;
      last_addr = 0;
      last_a    = 0;
      last_b    = 0;
      last_s    = 0;
    end else begin
      chk("tw_valid_latency", int'(tw_valid), int'(prev_en));
      if (tw_valid) begin
        if (!active || tv_i >= iss_i) begin
          flag("spurious_tw_valid");
        end else begin
          chk("idx_a", idx_a, e_a[tv_i]);
          chk("idx_b", idx_b, e_b[tv_i]);
          chk("stage", stage, e_s[tv_i]);
          last_a = e_a[tv_i];
          last_b = e_b[tv_i];
          last_s = e_s[tv_i];
          tv_i++;
        end
      end else begin
        chk("idx_a_hold", idx_a, last_a);
        chk("idx_b_hold", idx_b, last_b);
        chk("stage_hold", stage, last_s);
      end
      if (rom_en) begin
        if (!active || iss_i >= 12) begin
          flag("spurious_rom_en");
        end else begin
          chk("rom_addr", rom_addr, e_addr[iss_i]);
          addr_log.push_back(int'(rom_addr));
          last_addr = e_addr[iss_i];
          iss_i++;
        end
      end else begin
        chk("rom_addr_hold", rom_addr, last_addr);
      end
      if (done) done_cnt++;
      prev_en = rom_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(int g);
    tick();
    start   = 1'b1;
    grp_sel = 3'(g);
    t0      = cyc;
    if (g < 7) load_model(g);
    model_ok = (g < 7);
    gen++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, int want);
    bit seen;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      flag({nm, "_done_timeout"});
    end else begin
      chk({nm, "_done_cycle"}, cyc - t0, want);
      @(negedge clk);
      chk({nm, "_done_pulse"}, int'(done), 0);
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_issues"}, iss_i, 12);
      chk({nm, "_tw_count"}, tv_i, 12);
    end
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_addr"}, rom_addr, 0);
    chk({nm, "_en"}, int'(rom_en), 0);
    chk({nm, "_tv"}, int'(tw_valid), 0);
    chk({nm, "_a"}, idx_a, 0);
    chk({nm, "_b"}, idx_b, 0);
    chk({nm, "_stage"}, stage, 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_err"}, int'(err), 0);
  endtask

  initial begin
    int lit[12];
    int dc;
    lit = '{8, 8, 8, 8, 8, 10, 8, 10, 8, 9, 10, 11};

    #1 rst = 1'b1;
    #1 chk_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    // nominal frame, group 2
    do_start(2);
    chk("model_s1_a0", e_a[4], 0);
    chk("model_s1_b1", e_b[5], 3);
    chk("model_s1_a2", e_a[6], 4);
    chk("model_s1_b3", e_b[7], 7);
    chk("model_s2_a3", e_a[11], 3);
    chk("model_s2_b0", e_b[8], 4);
    chk("model_s0_b3", e_b[3], 7);
    chk("model_addr9", e_addr[9], 9);
    @(negedge clk);
    chk("busy_run", int'(busy), 1);
    wait_done("nominal", 14 + 2 * GAP);
    if (addr_log.size() != 12) begin
      flag("addr_log_size");
    end else begin
      for (int i = 0; i < 12; i++) chk("addr_seq_lit", addr_log[i], lit[i]);
    end

    // stall at s=1,b=2 (cycle 9) for three cycles
    do_start(4);
    repeat (8) tick();
    bf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rom_en", int'(rom_en), 0);
      tick();
    end
    bf_ready = 1'b1;
    wait_done("stall", 14 + 2 * GAP + 3);

    // rejected group
    do_start(7);
    @(negedge clk);
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    tick();
    @(negedge clk);
    chk("err_clear", int'(err), 0);
    chk("err_busy2", int'(busy), 0);
    repeat (4) tick();

    // start during RUN is ignored
    do_start(1);
    repeat (4) tick();
    start   = 1'b1;
    grp_sel = 3'd3;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("ignored_start_err", int'(err), 0);
    wait_done("ignored_start", 14 + 2 * GAP);

    // reset during stage 2, butterfly 1
    dc = done_cnt;
    do_start(6);
    repeat (13) tick();
    chk("pre_rst_en", int'(rom_en), 1);
    chk("pre_rst_addr", rom_addr, 25);
    rst = 1'b1;
    #1 chk_zero("midreset");
    tick();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("abort_no_done", done_cnt, dc);

    do_start(0);
    wait_done("post_reset", 14 + 2 * GAP);
    if (addr_log.size() != 12) begin
      flag("post_reset_log_size");
    end else begin
      for (int i = 0; i < 4; i++) chk("post_reset_s2_addr", addr_log[8 + i], i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/twiddle_addr_seq.md
TWIDDLE_ADDR_SEQ -- requirements
Module: twiddle_addr_seq

Interface
REQ-001 SHALL have parameter STAGE_GAP, default 2, idle cycles between stages for butterfly write-back (0..15).
REQ-002 SHALL have parameter NUM_GROUPS, default 7, number of valid 4-entry twiddle groups in the ROM.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to run one 8-point frame.
REQ-006 SHALL have port grp_sel  input  3  twiddle group (scale) for the frame; sampled with start.
REQ-007 SHALL have port bf_ready  input  1  butterfly can accept an operation this cycle.
REQ-008 SHALL have port rom_addr  output  5  twiddle ROM address.
REQ-009 SHALL have port rom_en  output  1  address valid this cycle.
REQ-010 SHALL have port tw_valid  output  1  ROM data valid this cycle (rom_en delayed 1).
REQ-011 SHALL have port idx_a, idx_b  output  3 each  butterfly operand indices, aligned with tw_valid.
REQ-012 SHALL have port stage  output  2  current stage 0..2, aligned with tw_valid.
REQ-013 SHALL have ports busy, done, err  output  1 each  frame active, end-of-frame pulse, rejected-start pulse.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP, DRAIN, DONE.
REQ-015 IDLE: start=1 and grp_sel<NUM_GROUPS SHALL latch grp_sel, clear s=0, b=0, enter RUN next cycle; busy=1 from that cycle.
REQ-016 IDLE: start=1 and grp_sel>=NUM_GROUPS SHALL pulse err for one cycle and stay IDLE.
REQ-017 start outside IDLE SHALL be ignored (no err, no restart).
REQ-018 RUN: bf_ready=1 SHALL assert rom_en, issue one butterfly (s,b), then advance b; bf_ready=0 SHALL deassert rom_en and hold s,b.
REQ-019 Twiddle exponent SHALL be k = (b mod 2^s) << (2-s); rom_addr = grp*4 + k (5-bit, no overflow for grp<=6).
REQ-020 Operands SHALL be pos = b mod 2^s, idx_a = (b>>s)*2^(s+1) + pos, idx_b = idx_a + 2^s.
REQ-021 After b=3 issues with s<2: enter GAP for STAGE_GAP cycles (skip GAP if 0), then RUN with s+1, b=0.
REQ-022 After b=3 issues with s=2: enter DRAIN for 1 cycle (last tw_valid), then DONE.
REQ-023 DONE SHALL pulse done for exactly one cycle, busy=0 from the next cycle, return to IDLE.
REQ-024 tw_valid, idx_a, idx_b, stage SHALL be registered copies of rom_en's issue values with exactly 1-cycle latency, matching synchronous ROM read.
REQ-025 A frame with bf_ready held high SHALL take 12 issue cycles + 2*STAGE_GAP + 1 drain; done asserted on cycle 14+2*STAGE_GAP after start.
REQ-026 rom_addr SHALL hold its last value when rom_en=0; idx/stage SHALL hold when tw_valid=0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, rom_addr=0, rom_en=0, tw_valid=0, idx_a=0, idx_b=0, stage=0, busy=0, done=0, err=0, counters 0.
REQ-028 Reset mid-frame SHALL abort without done pulse; first post-reset start SHALL run a full frame from s=0,b=0.

Structure
REQ-029 State encoding, N=8, LOG2N=3, group width (4 entries) SHALL live in shared package ifft_pkg.
REQ-030 Address/index arithmetic SHALL be one combinational sub-module bf_index_calc (s,b,grp -> addr,idx_a,idx_b); FSM and pipeline register in the top.

Verification
REQ-031 start, grp_sel=2, bf_ready=1, STAGE_GAP=2 -> rom_addr sequence 8,8,8,8 | 8,10,8,10 | 8,9,10,11; done on cycle 18.
REQ-032 Stage 1 pairs SHALL be (0,2),(1,3),(4,6),(5,7); stage 2 pairs (0,4),(1,5),(2,6),(3,7); stage 0 (0,1),(2,3),(4,5),(6,7).
REQ-033 bf_ready low for 3 cycles at s=1,b=2 -> rom_en low 3 cycles, no skipped/duplicated issue, done delayed by 3.
REQ-034 start with grp_sel=7 -> err 1 cycle, busy stays 0, rom_en never asserted.
REQ-035 rst asserted at s=2,b=1 -> all outputs 0 same cycle, no done; next start grp_sel=0 -> addresses 0..3 in stage 2.
REQ-036 start pulsed during RUN -> ignored; exactly 12 tw_valid pulses per frame.
